// File: rtl/mdu_defs.sv
// Shared encodings for the multiply/divide unit.
// Holds mdop codes, FSM states and a small signedness helper.
package mdu_defs;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MADDU = 4'd10,
    MD_MSUB  = 4'd11,
    MD_MSUBU = 4'd12
  } mdop_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MULT_RUN = 2'd1,
    S_DIV_RUN  = 2'd2
  } state_e;

  function automatic logic op_signed(logic [3:0] op);
    return (op == MD_MULT) || (op == MD_DIV) ||
           (op == MD_MADD) || (op == MD_MSUB);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit {HI,LO} result for the latched md op.
// MDU_MADD_EN adds the MADD/MADDU/MSUB/MSUBU accumulate forms.
module mdu_calc
  import mdu_defs::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res
);

  logic        sgn;
  logic [63:0] xa;
  logic [63:0] xb;
  logic [63:0] prod;
  logic        na;
  logic        nb;
  logic [31:0] ma;
  logic [31:0] mb;
  logic [31:0] q;
  logic [31:0] r;
  logic [31:0] qs;
  logic [31:0] rs;

  assign sgn  = op_signed(op);
  assign xa   = {{32{sgn & a[31]}}, a};
  assign xb   = {{32{sgn & b[31]}}, b};
  assign prod = xa * xb;

  // Signed divide on magnitudes; quotient sign from both, remainder from dividend.
  assign na = sgn & a[31];
  assign nb = sgn & b[31];
  assign ma = na ? -a : a;
  assign mb = nb ? -b : b;
  assign q  = (mb == 32'd0) ? 32'd0 : ma / mb;
  assign r  = (mb == 32'd0) ? 32'd0 : ma % mb;
  assign qs = (na ^ nb) ? -q : q;
  assign rs = na ? -r : r;

  // Select result; divide by zero hands back the current HI/LO.
  always_comb begin
    res = {hi, lo};
    unique case (op)
      MD_MULT, MD_MULTU: res = prod;
      MD_DIV, MD_DIVU: begin
        if (b != 32'd0) res = {rs, qs};
      end
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU: res = {hi, lo} + prod;
      MD_MSUB, MD_MSUBU: res = {hi, lo} - prod;
`endif
      default: res = {hi, lo};
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: HI/LO owner, busy and D-stage stall source.
// MDU_MADD_EN enables the multiply-accumulate mdop codes.
module mdu_ctrl
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        start,
  input  logic [3:0]  mdop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_in_D,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_rd
);

  localparam logic [3:0] MC = 4'(MULT_CYCLES);
  localparam logic [3:0] DC = 4'(DIV_CYCLES);

  state_e      state;
  state_e      state_n;
  logic [3:0]  cnt;
  logic [3:0]  cnt_n;
  logic [3:0]  op_q;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] hi_n;
  logic [31:0] lo_n;
  logic        lat;
  logic        issue;
  logic        is_mul;
  logic        is_div;
  logic [63:0] res;

  assign issue = start & ~Req & (state == S_IDLE);
  assign busy  = (state != S_IDLE);
  assign stall = md_in_D & (busy | (issue & (is_mul | is_div)));

  // Classify the incoming op as a multi-cycle multiply or divide.
  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    unique case (mdop)
      MD_MULT, MD_MULTU: is_mul = 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: is_mul = 1'b1;
`endif
      MD_DIV, MD_DIVU: is_div = 1'b1;
      default: ;
    endcase
  end

  // MFHI/MFLO read path straight off the architectural registers.
  always_comb begin
    md_rd = 32'd0;
    unique case (mdop)
      MD_MFHI: md_rd = HI;
      MD_MFLO: md_rd = LO;
      default: ;
    endcase
  end

  mdu_calc u_calc (
    .op  (op_q),
    .a   (op_a),
    .b   (op_b),
    .hi  (HI),
    .lo  (LO),
    .res (res)
  );

  // Next state, counter and HI/LO updates.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = HI;
    lo_n    = LO;
    lat     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (issue) begin
          if (is_mul) begin
            state_n = S_MULT_RUN;
            cnt_n   = MC;
            lat     = 1'b1;
          end else if (is_div) begin
            state_n = S_DIV_RUN;
            cnt_n   = DC;
            lat     = 1'b1;
          end else if (mdop == MD_MTHI) begin
            hi_n = A;
          end else if (mdop == MD_MTLO) begin
            lo_n = A;
          end
        end
      end
      S_MULT_RUN, S_DIV_RUN: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_n = S_IDLE;
          cnt_n   = 4'd0;
          hi_n    = res[63:32];
          lo_n    = res[31:0];
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  // FSM, counter and architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      HI    <= hi_n;
      LO    <= lo_n;
    end
  end

  // Operand latch so results never follow live forwarded operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= 4'd0;
      op_a <= 32'd0;
      op_b <= 32'd0;
    end else if (lat) begin
      op_q <= mdop;
      op_a <= A;
      op_b <= B;
    end
  end

endmodule
